// File: rtl/wb_pkg.sv
// Shared types for the register write-back queue: entry payload and source ordering.
package wb_pkg;

  localparam int unsigned WB_D = 5;
  localparam int unsigned WB_W = 32;
  localparam int unsigned WB_F = 2;

  typedef struct packed {
    logic [WB_D-1:0] address;
    logic [WB_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_MEM = 1'b0,
    WB_SRC_ALU = 1'b1
  } wb_src_e;

  // Memory results commit ahead of ALU results accepted in the same cycle.
  localparam wb_src_e WB_FIRST_SRC = WB_SRC_MEM;

endpackage

// File: rtl/writeback_fifo.sv
// In-order circular buffer: up to two enqueues and one dequeue per cycle.
// Caller guarantees capacity for every enqueue and only dequeues when count != 0.
module writeback_fifo
  import wb_pkg::*;
#(
  parameter int unsigned F = WB_F
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enq0_valid,
  input  wb_entry_t                   enq0,
  input  logic                        enq1_valid,
  input  wb_entry_t                   enq1,
  input  logic                        deq,
  output logic [F:0]                  count,
  output wb_entry_t                   head,
  output wb_entry_t [(1<<F)-1:0]      entries,
  output logic [(1<<F)-1:0]           slot_valid
);

  localparam int unsigned DEPTH = 1 << F;

  wb_entry_t [DEPTH-1:0] mem;
  logic [F-1:0]          wr_ptr;
  logic [F-1:0]          rd_ptr;
  logic [1:0]            n_enq;
  logic [F-1:0]          off;

  assign n_enq = 2'(enq0_valid) + 2'(enq1_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + F'(n_enq);
      rd_ptr <= rd_ptr + F'(deq);
      count  <= count + (F+1)'(n_enq) - (F+1)'(deq);
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (enq0_valid) mem[wr_ptr] <= enq0;
    if (enq1_valid) mem[wr_ptr + F'(enq0_valid)] <= enq1;
  end

  always_comb begin
    slot_valid = '0;
    off        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off           = F'(i) - rd_ptr;
      slot_valid[i] = ((F+1)'(off) < count);
    end
  end

  assign entries = mem;
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/register_writeback.sv
// Register-file write front end: arbitrates ALU/load results into an in-order queue.
// Optional WB_ZERO_REG_EN: results targeting register 0 are accepted but dropped.
module register_writeback
  import wb_pkg::*;
#(
  parameter int unsigned D = WB_D,
  parameter int unsigned W = WB_W,
  parameter int unsigned F = WB_F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic [D-1:0]      mem_address,
  input  logic [W-1:0]      mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [D-1:0]      alu_address,
  input  logic [W-1:0]      alu_data,
  output logic              alu_ready,
  output logic [D-1:0]      address3,
  output logic [W-1:0]      write_data,
  output logic              write_enable,
  output logic [(1<<D)-1:0] pending,
  output logic [F:0]        count
);

  localparam int unsigned DEPTH = 1 << F;

  wb_entry_t             mem_e, alu_e, enq0, enq1, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      slot_valid;
  logic                  mem_fire, alu_fire, mem_enq, alu_enq, enq0_valid, enq1_valid;

  // Readiness comes from registered occupancy only; the same-cycle write is not credited.
  assign mem_ready = (count < (F+1)'(DEPTH));
  assign alu_ready = mem_valid ? (count < (F+1)'(DEPTH - 1)) : (count < (F+1)'(DEPTH));

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;

`ifdef WB_ZERO_REG_EN
  assign mem_enq = mem_fire && (mem_address != '0);
  assign alu_enq = alu_fire && (alu_address != '0);
`else
  assign mem_enq = mem_fire;
  assign alu_enq = alu_fire;
`endif

  assign mem_e = '{address: mem_address, data: mem_data};
  assign alu_e = '{address: alu_address, data: alu_data};

  always_comb begin
    enq0       = mem_e;
    enq0_valid = mem_enq;
    enq1       = alu_e;
    enq1_valid = alu_enq;
    if (WB_FIRST_SRC == WB_SRC_ALU) begin
      enq0       = alu_e;
      enq0_valid = alu_enq;
      enq1       = mem_e;
      enq1_valid = mem_enq;
    end
  end

  writeback_fifo #(.F(F)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq0_valid (enq0_valid),
    .enq0       (enq0),
    .enq1_valid (enq1_valid),
    .enq1       (enq1),
    .deq        (write_enable),
    .count      (count),
    .head       (head),
    .entries    (entries),
    .slot_valid (slot_valid)
  );

  assign write_enable = (count != '0);
  assign address3     = head.address;
  assign write_data   = head.data;

  // Bitmap of registers with at least one queued write.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pending[entries[i].address] = 1'b1;
    end
`ifdef WB_ZERO_REG_EN
    pending[0] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_register_writeback.sv
// Directed self-checking bench for register_writeback (D=5, W=32, F=2).
module tb_register_writeback;

  localparam int unsigned D = 5;
  localparam int unsigned W = 32;
  localparam int unsigned F = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_valid, alu_valid;
  logic [D-1:0]      mem_address, alu_address;
  logic [W-1:0]      mem_data, alu_data;
  logic              mem_ready, alu_ready;
  logic [D-1:0]      address3;
  logic [W-1:0]      write_data;
  logic              write_enable;
  logic [(1<<D)-1:0] pending;
  logic [F:0]        count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [D+W-1:0] sb[$];
  logic [D+W-1:0] front;

  register_writeback #(.D(D), .W(W), .F(F)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .alu_valid    (alu_valid),
    .alu_address  (alu_address),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .address3     (address3),
    .write_data   (write_data),
    .write_enable (write_enable),
    .pending      (pending),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid   = 1'b0;
    alu_valid   = 1'b0;
    mem_address = '0;
    alu_address = '0;
    mem_data    = '0;
    alu_data    = '0;
  endtask

  initial begin
    int exp_count;
    logic exp_mrdy, exp_ardy;

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_addr", 64'(address3), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ALU write
    alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    check("t1_we", 64'(write_enable), 64'd1);
    check("t1_addr", 64'(address3), 64'd3);
    check("t1_data", 64'(write_data), 64'hDEADBEEF);
    check("t1_pending", 64'(pending), 64'h8);
    step();
    check("t1_we_off", 64'(write_enable), 64'd0);
    check("t1_pending_off", 64'(pending), 64'd0);

    // Both sources in one cycle: memory first
    mem_valid = 1'b1; mem_address = 5'd5; mem_data = 32'h11;
    alu_valid = 1'b1; alu_address = 5'd6; alu_data = 32'h22;
    #1;
    check("t2_alu_ready", 64'(alu_ready), 64'd1);
    step();
    idle_inputs();
    check("t2_count", 64'(count), 64'd2);
    check("t2_addr0", 64'(address3), 64'd5);
    check("t2_data0", 64'(write_data), 64'h11);
    check("t2_pending", 64'(pending), 64'h60);
    step();
    check("t2_we1", 64'(write_enable), 64'd1);
    check("t2_addr1", 64'(address3), 64'd6);
    check("t2_data1", 64'(write_data), 64'h22);
    check("t2_pending1", 64'(pending), 64'h40);
    step();
    check("t2_we_off", 64'(write_enable), 64'd0);

    // Both sources held valid: occupancy tops out, order preserved
    exp_count = 0;
    sb.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      mem_valid = 1'b1; mem_address = 5'(8 + cyc);  mem_data = 32'h1000 + 32'(cyc);
      alu_valid = 1'b1; alu_address = 5'(16 + cyc); alu_data = 32'h2000 + 32'(cyc);
      #1;
      exp_mrdy = (exp_count < 4);
      exp_ardy = (exp_count < 3);
      check("sat_mem_ready", 64'(mem_ready), 64'(exp_mrdy));
      check("sat_alu_ready", 64'(alu_ready), 64'(exp_ardy));
      check("sat_we", 64'(write_enable), 64'(exp_count != 0));
      if (exp_count != 0) begin
        front = sb.pop_front();
        check("sat_head", 64'({address3, write_data}), 64'(front));
        exp_count--;
      end
      if (exp_mrdy) begin sb.push_back({mem_address, mem_data}); exp_count++; end
      if (exp_ardy) begin sb.push_back({alu_address, alu_data}); exp_count++; end
      step();
      check("sat_count", 64'(count), 64'(exp_count));
    end
    idle_inputs();
    for (int n = 0; n < 8 && sb.size() != 0; n++) begin
      front = sb.pop_front();
      check("drain_we", 64'(write_enable), 64'd1);
      check("drain_head", 64'({address3, write_data}), 64'(front));
      step();
    end
    check("drain_count", 64'(count), 64'd0);

    // Duplicate destination: pending holds until the last write
    mem_valid = 1'b1; mem_address = 5'd7; mem_data = 32'hA;
    alu_valid = 1'b1; alu_address = 5'd7; alu_data = 32'hB;
    step();
    idle_inputs();
    check("dup_pending_a", 64'(pending), 64'h80);
    check("dup_data_a", 64'(write_data), 64'hA);
    step();
    check("dup_pending_b", 64'(pending), 64'h80);
    check("dup_data_b", 64'(write_data), 64'hB);
    step();
    check("dup_pending_clr", 64'(pending), 64'd0);

    // Register 0 destination
    alu_valid = 1'b1; alu_address = 5'd0; alu_data = 32'h55;
    #1;
    check("z_alu_ready", 64'(alu_ready), 64'd1);
    step();
    idle_inputs();
`ifdef WB_ZERO_REG_EN
    check("z_we", 64'(write_enable), 64'd0);
    check("z_count", 64'(count), 64'd0);
    check("z_pending", 64'(pending), 64'd0);
`else
    check("z_we", 64'(write_enable), 64'd1);
    check("z_addr", 64'(address3), 64'd0);
    check("z_data", 64'(write_data), 64'h55);
    check("z_pending", 64'(pending), 64'd1);
`endif
    step();

    // Mid-cycle reset discards queued entries
    mem_valid = 1'b1; mem_address = 5'd1; mem_data = 32'h101;
    alu_valid = 1'b1; alu_address = 5'd2; alu_data = 32'h102;
    step();
    mem_address = 5'd3; mem_data = 32'h103;
    alu_address = 5'd4; alu_data = 32'h104;
    step();
    idle_inputs();
    check("rr_count_pre", 64'(count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_count", 64'(count), 64'd0);
    check("rr_we", 64'(write_enable), 64'd0);
    check("rr_pending", 64'(pending), 64'd0);
    check("rr_addr", 64'(address3), 64'd0);
    check("rr_data", 64'(write_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check("rr_we_after", 64'(write_enable), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
